// File: rtl/imem_loader.sv
// Boot-time program loader: parses SYNC/LEN/data/CSUM frames from a host byte stream,
// writes the data into instruction memory and holds the CPU core in reset until a good frame lands.
module imem_loader #(
    parameter int              DATA_W = 8,
    parameter int              ADDR_W = 8,
    parameter logic [DATA_W-1:0] SYNC = 8'hA5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [DATA_W-1:0] len;
    logic [DATA_W-1:0] sum;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] count_inc;
    logic              accept;

    // The loader never stalls the host; every offered byte is consumed.
    assign in_ready  = 1'b1;
    assign accept    = in_valid & in_ready;
    assign count_inc = count + 1'b1;

    always_comb begin
        state_next = state;
        if (accept) begin
            case (state)
                S_IDLE, S_RUN, S_ERR: begin
                    if (in_data == SYNC) state_next = S_LEN;
                end
                S_LEN: begin
                    if (in_data == '0) state_next = S_ERR;
                    else               state_next = S_DATA;
                end
                S_DATA: begin
                    if (count_inc == ADDR_W'(len)) state_next = S_CSUM;
                end
                S_CSUM: begin
                    if (in_data == sum) state_next = S_RUN;
                    else                state_next = S_ERR;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Status flags are registered from the next state so they move with the state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            len        <= '0;
            sum        <= '0;
            count      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state     <= state_next;
            cpu_reset <= (state_next != S_RUN);
            load_done <= (state_next == S_RUN);
            load_err  <= (state_next == S_ERR);
            imem_we   <= 1'b0;
            if (accept) begin
                case (state)
                    S_LEN: begin
                        if (in_data != '0) begin
                            len   <= in_data;
                            count <= '0;
                            sum   <= '0;
                        end
                    end
                    S_DATA: begin
                        imem_we    <= 1'b1;
                        imem_addr  <= count;
                        imem_wdata <= in_data;
                        sum        <= sum + in_data;
                        count      <= count_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-level reference model feeds a write scoreboard
// and status expectations; an independent monitor checks every write strobe.
module tb_imem_loader;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       imem_we;
    logic [7:0] imem_addr;
    logic [7:0] imem_wdata;
    logic       cpu_reset;
    logic       load_done;
    logic       load_err;

    int checks;
    int failures;

    logic [15:0] exp_q[$];
    logic [7:0]  frame_data[256];

    imem_loader dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (!reset && imem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_write: got addr %0h data %0h expected no write at %0t",
                         imem_addr, imem_wdata, $time);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    failures++;
                    $display("[TB] FAIL write: got addr %0h data %0h expected addr %0h data %0h at %0t",
                             imem_addr, imem_wdata, e[15:8], e[7:0], $time);
                end
            end
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clock);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic checkStatus(input string tag, input logic done, input logic err, input logic crst);
        checkOutput({tag, "_load_done"}, 32'(load_done), 32'(done));
        checkOutput({tag, "_load_err"},  32'(load_err),  32'(err));
        checkOutput({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(crst));
    endtask

    task automatic applyReset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #12;
        checkStatus("reset", 1'b0, 1'b0, 1'b1);
        checkOutput("reset_imem_we", 32'(imem_we), 32'd0);
        checkOutput("reset_imem_addr", 32'(imem_addr), 32'd0);
        checkOutput("reset_imem_wdata", 32'(imem_wdata), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Reference: a frame with len data bytes yields writes 0..len-1 and an outcome decided
    // purely by whether the transmitted checksum equals the byte sum modulo 256.
    task automatic sendFrame(input string tag, input int len, input logic [7:0] csum_delta, input int max_gap);
        int          s;
        logic [7:0]  csum;
        applyStimulus(8'hA5, max_gap);
        checkStatus({tag, "_sync"}, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'(len), max_gap);
        if (len == 0) begin
            checkStatus({tag, "_len0"}, 1'b0, 1'b1, 1'b1);
            return;
        end
        s = 0;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({8'(i), frame_data[i]});
            applyStimulus(frame_data[i], max_gap);
            s = (s + frame_data[i]) % 256;
        end
        csum = 8'(s) + csum_delta;
        checkOutput({tag, "_pre_csum_cpu_reset"}, 32'(cpu_reset), 32'd1);
        applyStimulus(csum, max_gap);
        if (csum_delta == 8'd0) checkStatus({tag, "_good"}, 1'b1, 1'b0, 1'b0);
        else                    checkStatus({tag, "_bad"},  1'b0, 1'b1, 1'b1);
    endtask

    task automatic sendJunk(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            do b = 8'($urandom); while (b == 8'hA5);
            applyStimulus(b, 2);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        applyReset();

        // T1
        frame_data[0] = 8'h11; frame_data[1] = 8'h22; frame_data[2] = 8'h33;
        sendFrame("t1", 3, 8'd0, 0);
        idle(2);
        checkStatus("t1_hold", 1'b1, 1'b0, 1'b0);

        // T4: re-sync from RUN, then SYNC value carried as data
        frame_data[0] = 8'hA5;
        sendFrame("t4", 1, 8'd0, 0);
        idle(2);

        // T2
        frame_data[0] = 8'h10; frame_data[1] = 8'h20;
        sendFrame("t2", 2, 8'd1, 0);
        idle(2);
        checkStatus("t2_hold", 1'b0, 1'b1, 1'b1);
        frame_data[0] = 8'h07;
        sendFrame("t2b", 1, 8'd0, 0);
        idle(2);

        // T3
        applyReset();
        applyStimulus(8'h00, 0);
        applyStimulus(8'hFF, 0);
        checkStatus("t3_discard", 1'b0, 1'b0, 1'b1);
        sendFrame("t3", 0, 8'd0, 0);
        idle(2);

        // T5: full-length frame with random valid gaps
        for (int i = 0; i < 255; i++) frame_data[i] = 8'($urandom);
        sendFrame("t5", 255, 8'd0, 3);
        idle(2);

        // T6: reset mid-DATA after 2 of 4 bytes
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h04, 0);
        exp_q.push_back({8'h00, 8'h5A});
        applyStimulus(8'h5A, 0);
        exp_q.push_back({8'h01, 8'hC3});
        applyStimulus(8'hC3, 0);
        idle(1);
        #2;
        reset = 1'b1;
        #1;
        checkStatus("t6_async", 1'b0, 1'b0, 1'b1);
        checkOutput("t6_imem_we", 32'(imem_we), 32'd0);
        checkOutput("t6_imem_addr", 32'(imem_addr), 32'd0);
        checkOutput("t6_imem_wdata", 32'(imem_wdata), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) frame_data[i] = 8'($urandom);
        sendFrame("t6", 4, 8'd0, 1);
        idle(2);

        // Random frames with junk between them
        for (int f = 0; f < 25; f++) begin
            int         len;
            logic [7:0] delta;
            len = $urandom_range(0, 12);
            delta = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            for (int i = 0; i < len; i++) frame_data[i] = 8'($urandom);
            sendFrame("rand", len, delta, 2);
            sendJunk($urandom_range(0, 3));
            if (len == 0)           checkStatus("rand_junk", 1'b0, 1'b1, 1'b1);
            else if (delta == 8'd0) checkStatus("rand_junk", 1'b1, 1'b0, 1'b0);
            else                    checkStatus("rand_junk", 1'b0, 1'b1, 1'b1);
        end

        idle(4);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
